// File: rtl/camera_pixel_capture.sv
// Captures the 8-bit sensor bus sampled on recovered pixel_clock edges, packs byte pairs into
// RGB565 pixels tagged with x/y, and buffers them in a small FIFO feeding a valid/ready stream.
module camera_pixel_capture #(
  parameter int frame_width  = 640,
  parameter int frame_height = 480,
  parameter int x_width      = 10,
  parameter int y_width      = 9,
  parameter int fifo_depth   = 4
) (
  input  logic               input_clock,
  input  logic               reset,
  input  logic               pixel_clock,
  input  logic               vsync,
  input  logic               href,
  input  logic [7:0]         data,
  output logic [15:0]        pixel_data,
  output logic [x_width-1:0] pixel_x,
  output logic [y_width-1:0] pixel_y,
  output logic               start_of_frame,
  output logic               end_of_line,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               overflow
);

  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = aw + 1;
  localparam logic [x_width:0]   x_lim  = (x_width + 1)'(frame_width);
  localparam logic [y_width:0]   y_lim  = (y_width + 1)'(frame_height);
  localparam logic [x_width-1:0] x_last = x_width'(frame_width - 1);
  localparam logic [x_width-1:0] x_max  = '1;
  localparam logic [y_width-1:0] y_max  = '1;
  localparam logic [cw-1:0]      cnt_full = cw'(fifo_depth);

  typedef enum logic [1:0] {
    st_idle       = 2'd0,
    st_frame_sync = 2'd1,
    st_active     = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0]        pix;
    logic [x_width-1:0] x;
    logic [y_width-1:0] y;
  } entry_t;

  // sync word layout: {pixel_clock, vsync, href, data}
  logic [10:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic        pclk_s3_q, pclk_s3_d;

  state_t             state_q, state_d;
  logic [x_width-1:0] x_q, x_d;
  logic [y_width-1:0] y_q, y_d;
  logic               phase_q, phase_d;
  logic               line_q, line_d;
  logic [7:0]         hi_q, hi_d;

  entry_t        mem_q [fifo_depth];
  entry_t        mem_d [fifo_depth];
  logic [aw-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cw-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          edge_evt, s_vsync, s_href;
  logic [7:0]    s_data;
  logic          push_req, push_ok, pop, full;
  entry_t        push_entry, head;

  assign edge_evt = sync2_q[10] & ~pclk_s3_q;
  assign s_vsync  = sync2_q[9];
  assign s_href   = sync2_q[8];
  assign s_data   = sync2_q[7:0];

  always_comb begin
    sync1_d   = {pixel_clock, vsync, href, data};
    sync2_d   = sync1_q;
    pclk_s3_d = sync2_q[10];
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    phase_d    = phase_q;
    line_d     = line_q;
    hi_d       = hi_q;
    push_req   = 1'b0;
    push_entry = '{pix: {hi_q, s_data}, x: x_q, y: y_q};
    if (edge_evt) begin
      unique case (state_q)
        st_idle: begin
          if (s_vsync) begin
            state_d = st_frame_sync;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
            line_d  = 1'b0;
          end
        end
        st_frame_sync: begin
          if (!s_vsync) state_d = st_active;
        end
        st_active: begin
          if (s_vsync) begin
            state_d = st_frame_sync;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
            line_d  = 1'b0;
          end else if (s_href) begin
            line_d = 1'b1;
            if (!phase_q) begin
              hi_d    = s_data;
              phase_d = 1'b1;
            end else begin
              phase_d  = 1'b0;
              // x saturates so an over-long line can never wrap back into the visible window
              x_d      = (x_q == x_max) ? x_q : x_q + 1'b1;
              push_req = ({1'b0, x_q} < x_lim) && ({1'b0, y_q} < y_lim);
            end
          end else if (line_q) begin
            x_d     = '0;
            phase_d = 1'b0;
            line_d  = 1'b0;
            y_d     = (y_q == y_max) ? y_q : y_q + 1'b1;
          end
        end
        default: state_d = st_idle;
      endcase
    end
  end

  always_comb begin
    full     = (count_q == cnt_full);
    pop      = (count_q != '0) & pixel_ready;
    push_ok  = push_req & (~full | pop);
    ovf_d    = ovf_q | (push_req & full & ~pop);
    rd_ptr_d = pop ? rd_ptr_q + aw'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + aw'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + cw'(1);
    else if (!push_ok && pop) count_d = count_q - cw'(1);
    for (int i = 0; i < fifo_depth; i++) mem_d[i] = mem_q[i];
    if (push_ok) mem_d[wr_ptr_q] = push_entry;
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pclk_s3_q <= 1'b0;
      state_q   <= st_idle;
      x_q       <= '0;
      y_q       <= '0;
      phase_q   <= 1'b0;
      line_q    <= 1'b0;
      hi_q      <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pclk_s3_q <= pclk_s3_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      phase_q   <= phase_d;
      line_q    <= line_d;
      hi_q      <= hi_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // storage needs no reset: head outputs are gated by pixel_valid
  always_ff @(posedge input_clock) begin
    for (int i = 0; i < fifo_depth; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    head           = mem_q[rd_ptr_q];
    pixel_valid    = (count_q != '0);
    pixel_data     = pixel_valid ? head.pix : '0;
    pixel_x        = pixel_valid ? head.x : '0;
    pixel_y        = pixel_valid ? head.y : '0;
    start_of_frame = pixel_valid & (head.x == '0) & (head.y == '0);
    end_of_line    = pixel_valid & (head.x == x_last);
    overflow       = ovf_q;
  end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench for camera_pixel_capture (frame 4x2, FIFO depth 4): framing, packing,
// latency, back-pressure, overflow, odd bytes and mid-frame reset.
module tb_camera_pixel_capture;

  logic       clk = 1'b0;
  logic       reset, pclk, vsync, href, pixel_ready;
  logic [7:0] data;
  logic [15:0] pixel_data;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        start_of_frame, end_of_line, pixel_valid, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
  } pix_t;
  pix_t q[$];

  camera_pixel_capture #(
    .frame_width(4), .frame_height(2), .x_width(10), .y_width(9), .fifo_depth(4)
  ) dut (
    .input_clock(clk), .reset(reset), .pixel_clock(pclk), .vsync(vsync), .href(href),
    .data(data), .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .start_of_frame(start_of_frame), .end_of_line(end_of_line), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // record every handshake; pop happens at the following rising edge
  always @(negedge clk) begin
    if (pixel_valid && pixel_ready)
      q.push_back('{d: pixel_data, x: pixel_x, y: pixel_y, sof: start_of_frame, eol: end_of_line});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input int i, input logic [15:0] d, input int x, input int y,
                           input logic sof, input logic eol);
    check($sformatf("pix%0d_present", i), 64'(q.size() > i), 64'd1);
    if (q.size() > i)
      check($sformatf("pix%0d", i), {27'd0, q[i].d, q[i].x, q[i].y, q[i].sof, q[i].eol},
            {27'd0, d, 10'(x), 9'(y), sof, eol});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pbyte(input logic v, input logic h, input logic [7:0] d);
    pclk = 1'b0; vsync = v; href = h; data = d;
    cyc(3);
    pclk = 1'b1;
    cyc(3);
  endtask

  task automatic frame_start();
    pbyte(1'b1, 1'b0, 8'h00);
    pbyte(1'b1, 1'b0, 8'h00);
    pbyte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_pixels(input int n, input logic [7:0] hb, input logic [7:0] lb);
    for (int i = 0; i < n; i++) begin
      pbyte(1'b0, 1'b1, 8'(hb + i));
      pbyte(1'b0, 1'b1, 8'(lb + i));
    end
  endtask

  initial begin
    reset = 1'b1; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00; pixel_ready = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_valid", 64'(pixel_valid), 64'd0);
    check("rst_data", 64'(pixel_data), 64'd0);
    check("rst_xy", {pixel_x, pixel_y}, 64'd0);
    check("rst_flags", {start_of_frame, end_of_line, overflow}, 64'd0);

    // 1: one short line, latency of first pixel
    pixel_ready = 1'b1;
    frame_start();
    pbyte(1'b0, 1'b1, 8'h12);
    pclk = 1'b0; data = 8'h34;
    cyc(3);
    pclk = 1'b1;
    cyc(2);
    check("lat_early_valid", 64'(pixel_valid), 64'd0);
    cyc(1);
    check("lat_valid", 64'(pixel_valid), 64'd1);
    check("lat_head", {pixel_data, pixel_x, pixel_y, start_of_frame}, {16'h1234, 10'd0, 9'd0, 1'b1});
    cyc(3);
    pbyte(1'b0, 1'b1, 8'h56);
    pbyte(1'b0, 1'b1, 8'h78);
    pbyte(1'b0, 1'b0, 8'h00);
    cyc(2);
    check("t1_count", 64'(q.size()), 64'd2);
    check_pix(0, 16'h1234, 0, 0, 1'b1, 1'b0);
    check_pix(1, 16'h5678, 1, 0, 1'b0, 1'b0);

    // 2: full 4x2 frame with 8-pixel lines; x=4..7 suppressed
    q.delete();
    frame_start();
    send_pixels(8, 8'h40, 8'hC0);
    pbyte(1'b0, 1'b0, 8'h00);
    send_pixels(8, 8'h50, 8'hD0);
    pbyte(1'b0, 1'b0, 8'h00);
    cyc(4);
    check("t2_count", 64'(q.size()), 64'd8);
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 4; i++)
        check_pix(l*4 + i, {8'(8'h40 + 16*l + i), 8'(8'hC0 + 16*l + i)}, i, l,
                  (i == 0 && l == 0), (i == 3));
    check("t2_ovf", 64'(overflow), 64'd0);

    // 4: FIFO full, pop and push on the same edge
    q.delete();
    pixel_ready = 1'b0;
    frame_start();
    send_pixels(4, 8'h60, 8'h70);
    pbyte(1'b0, 1'b0, 8'h00);
    check("t4_full_head_x", 64'(pixel_x), 64'd0);
    pbyte(1'b0, 1'b1, 8'h68);
    pclk = 1'b0; data = 8'h78;
    cyc(3);
    pclk = 1'b1;
    cyc(2);
    pixel_ready = 1'b1;
    cyc(1);
    pixel_ready = 1'b0;
    check("t4_ovf", 64'(overflow), 64'd0);
    check("t4_valid", 64'(pixel_valid), 64'd1);
    check("t4_head_x", 64'(pixel_x), 64'd1);
    cyc(3);
    pixel_ready = 1'b1;
    cyc(10);
    check("t4_count", 64'(q.size()), 64'd5);
    for (int i = 0; i < 4; i++)
      check_pix(i, {8'(8'h60 + i), 8'(8'h70 + i)}, i, 0, (i == 0), (i == 3));
    check_pix(4, 16'h6878, 0, 1, 1'b0, 1'b0);
    check("t4_drained", 64'(pixel_valid), 64'd0);

    // 3: overflow on 6 pushes with consumer stalled
    q.delete();
    pixel_ready = 1'b0;
    frame_start();
    send_pixels(4, 8'h80, 8'h90);
    pbyte(1'b0, 1'b0, 8'h00);
    send_pixels(2, 8'hA0, 8'hB0);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_head", {pixel_valid, pixel_data, pixel_x, pixel_y}, {1'b1, 16'h8090, 10'd0, 9'd0});
    pixel_ready = 1'b1;
    cyc(8);
    check("t3_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check_pix(i, {8'(8'h80 + i), 8'(8'h90 + i)}, i, 0, (i == 0), (i == 3));
    check("t3_drained", 64'(pixel_valid), 64'd0);
    q.delete();
    pbyte(1'b0, 1'b0, 8'h00);
    frame_start();
    send_pixels(1, 8'hC1, 8'hC2);
    pbyte(1'b0, 1'b0, 8'h00);
    check_pix(0, 16'hC1C2, 0, 0, 1'b1, 1'b0);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 5: odd byte at end of line is discarded
    q.delete();
    frame_start();
    pbyte(1'b0, 1'b1, 8'h11);
    pbyte(1'b0, 1'b1, 8'h22);
    pbyte(1'b0, 1'b1, 8'h33);
    pbyte(1'b0, 1'b1, 8'h44);
    pbyte(1'b0, 1'b1, 8'h55);
    pbyte(1'b0, 1'b0, 8'h00);
    pbyte(1'b0, 1'b1, 8'h66);
    pbyte(1'b0, 1'b1, 8'h77);
    pbyte(1'b0, 1'b0, 8'h00);
    cyc(3);
    check("t5_count", 64'(q.size()), 64'd3);
    check_pix(0, 16'h1122, 0, 0, 1'b1, 1'b0);
    check_pix(1, 16'h3344, 1, 0, 1'b0, 1'b0);
    check_pix(2, 16'h6677, 0, 1, 1'b0, 1'b0);

    // 6: reset mid-line, no output until a fresh vsync sequence
    q.delete();
    pixel_ready = 1'b0;
    frame_start();
    pbyte(1'b0, 1'b1, 8'hAA);
    pbyte(1'b0, 1'b1, 8'hBB);
    pbyte(1'b0, 1'b1, 8'hCC);
    check("t6_pre_valid", 64'(pixel_valid), 64'd1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("t6_rst_state", {pixel_valid, overflow, pixel_data}, 64'd0);
    pixel_ready = 1'b1;
    send_pixels(2, 8'hE0, 8'hF0);
    pbyte(1'b0, 1'b0, 8'h00);
    send_pixels(1, 8'hE8, 8'hF8);
    pbyte(1'b0, 1'b0, 8'h00);
    cyc(3);
    check("t6_no_output", 64'(q.size()), 64'd0);
    check("t6_no_valid", 64'(pixel_valid), 64'd0);
    frame_start();
    pbyte(1'b0, 1'b1, 8'h9A);
    pbyte(1'b0, 1'b1, 8'hBC);
    pbyte(1'b0, 1'b0, 8'h00);
    cyc(3);
    check("t6_count", 64'(q.size()), 64'd1);
    check_pix(0, 16'h9ABC, 0, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
